// File: rtl/bresenham_tracer.sv
// All-octant integer Bresenham ray walker over grid index space.
// Emits one traversed cell per output beat, with range truncation and abort.
module bresenham_tracer #(
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int MAX_STEPS = 64,
  parameter int E_BITS    = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_BITS-1:0] x0,
  input  logic [Y_BITS-1:0] y0,
  input  logic [X_BITS-1:0] x1,
  input  logic [Y_BITS-1:0] y1,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_BITS-1:0] out_x,
  output logic [Y_BITS-1:0] out_y,
  output logic              out_last,
  output logic              out_hit,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_TRACE
  } state_t;

  state_t r_state, w_next;

  logic [X_BITS-1:0] r_x0, r_x1, r_cx, r_dx;
  logic [Y_BITS-1:0] r_y0, r_y1, r_cy, r_dy;
  logic              r_sx_neg, r_sy_neg;
  logic signed [E_BITS-1:0] r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [X_BITS-1:0] w_dx;
  logic [Y_BITS-1:0] w_dy;
  logic signed [E_BITS-1:0] w_err_init, w_err_nx;
  logic signed [E_BITS-1:0] w_dx_e, w_dy_e;
  logic signed [E_BITS:0]   w_e2, w_ndy, w_dxs;
  logic w_trace, w_at_end, w_cap, w_fire, w_adv;
  logic w_stepx, w_stepy;

  assign w_trace  = (r_state == S_TRACE);
  assign w_at_end = (r_cx == r_x1) && (r_cy == r_y1);
  assign w_cap    = (r_cnt == CNT_W'(MAX_STEPS - 1));
  assign w_fire   = w_trace & out_ready;
  assign w_adv    = w_fire & ~out_last;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = w_trace;
  assign out_last  = w_trace & (w_at_end | w_cap);
  assign out_hit   = w_trace & w_at_end;
  assign out_x     = r_cx;
  assign out_y     = r_cy;

  assign w_dx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_dy = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

  assign w_dx_e     = $signed({{(E_BITS-X_BITS){1'b0}}, w_dx});
  assign w_dy_e     = $signed({{(E_BITS-Y_BITS){1'b0}}, w_dy});
  assign w_err_init = w_dx_e - w_dy_e;

  // Both step decisions use the same pre-update doubled error.
  assign w_e2    = $signed({r_err, 1'b0});
  assign w_ndy   = -$signed({{(E_BITS+1-Y_BITS){1'b0}}, r_dy});
  assign w_dxs   = $signed({{(E_BITS+1-X_BITS){1'b0}}, r_dx});
  assign w_stepx = (w_e2 > w_ndy);
  assign w_stepy = (w_e2 < w_dxs);

  always_comb begin
    w_err_nx = r_err;
    if (w_stepx) w_err_nx = w_err_nx - $signed({{(E_BITS-Y_BITS){1'b0}}, r_dy});
    if (w_stepy) w_err_nx = w_err_nx + $signed({{(E_BITS-X_BITS){1'b0}}, r_dx});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = S_SETUP;
      S_SETUP: w_next = S_TRACE;
      S_TRACE: if (w_fire && out_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_err    <= '0;
      r_cnt    <= '0;
    end else if (!abort) begin
      if (r_state == S_IDLE && in_valid) begin
        r_x0 <= x0;
        r_y0 <= y0;
        r_x1 <= x1;
        r_y1 <= y1;
      end else if (r_state == S_SETUP) begin
        r_dx     <= w_dx;
        r_dy     <= w_dy;
        r_sx_neg <= (r_x1 < r_x0);
        r_sy_neg <= (r_y1 < r_y0);
        r_err    <= w_err_init;
        r_cx     <= r_x0;
        r_cy     <= r_y0;
        r_cnt    <= '0;
      end else if (w_adv) begin
        r_err <= w_err_nx;
        if (w_stepx) r_cx <= r_sx_neg ? r_cx - 1'b1 : r_cx + 1'b1;
        if (w_stepy) r_cy <= r_sy_neg ? r_cy - 1'b1 : r_cy + 1'b1;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bresenham_tracer.sv
// Directed testbench for bresenham_tracer.
// Main instance uses default range; second instance has MAX_STEPS=4.
module tb_bresenham_tracer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       in_valid, abort, out_ready;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic       in_ready, out_valid, out_last, out_hit, busy;
  logic [7:0] out_x;
  logic [6:0] out_y;

  logic       t_in_valid, t_abort, t_out_ready;
  logic [7:0] t_x0, t_x1;
  logic [6:0] t_y0, t_y1;
  logic       t_in_ready, t_out_valid, t_out_last, t_out_hit, t_busy;
  logic [7:0] t_out_x;
  logic [6:0] t_out_y;

  int checks   = 0;
  int failures = 0;

  bresenham_tracer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .out_hit(out_hit), .busy(busy)
  );

  bresenham_tracer #(.MAX_STEPS(4)) dut_trunc (
    .clock(clock), .reset(reset),
    .in_valid(t_in_valid), .in_ready(t_in_ready),
    .x0(t_x0), .y0(t_y0), .x1(t_x1), .y1(t_y1),
    .abort(t_abort),
    .out_valid(t_out_valid), .out_ready(t_out_ready),
    .out_x(t_out_x), .out_y(t_out_y),
    .out_last(t_out_last), .out_hit(t_out_hit), .busy(t_busy)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 0; abort = 0; out_ready = 1;
    x0 = 0; y0 = 0; x1 = 0; y1 = 0;
    t_in_valid = 0; t_abort = 0; t_out_ready = 1;
    t_x0 = 0; t_y0 = 0; t_x1 = 0; t_y1 = 0;
    tick;
    tick;
    checks++;
    if ({in_ready, out_valid, busy, out_last, out_hit, out_x, out_y}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b v=%b busy=%b last=%b hit=%b x=%0d y=%0d",
               in_ready, out_valid, busy, out_last, out_hit, out_x, out_y);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || t_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got rdy=%b busy=%b trdy=%b want 1 0 1",
               in_ready, busy, t_in_ready);
    end
  endtask

  task automatic test_shallow;
    int ex[4] = '{0, 1, 2, 3};
    int ey[4] = '{0, 0, 1, 1};
    x0 = 0; y0 = 0; x1 = 3; y1 = 1;
    in_valid = 1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL shallow_accept in_ready=%b want 1", in_ready);
    end
    tick;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL shallow_setup v=%b busy=%b want 0 1", out_valid, busy);
    end
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_x, out_y, out_last, out_hit}
          !== {1'b1, 8'(ex[i]), 7'(ey[i]), i == 3, i == 3}) begin
        failures++;
        $display("FAIL shallow_cell%0d got v=%b (%0d,%0d) l=%b h=%b want (%0d,%0d) l=h=%0d",
                 i, out_valid, out_x, out_y, out_last, out_hit, ex[i], ey[i], i == 3);
      end
      tick;
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL shallow_done rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_steep_neg;
    int ex[6] = '{5, 4, 4, 3, 3, 2};
    int ey[6] = '{7, 6, 5, 4, 3, 2};
    x0 = 5; y0 = 7; x1 = 2; y1 = 2;
    in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, out_x, out_y, out_last, out_hit}
          !== {1'b1, 8'(ex[i]), 7'(ey[i]), i == 5, i == 5}) begin
        failures++;
        $display("FAIL steep_cell%0d got v=%b (%0d,%0d) l=%b h=%b want (%0d,%0d) l=h=%0d",
                 i, out_valid, out_x, out_y, out_last, out_hit, ex[i], ey[i], i == 5);
      end
      tick;
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL steep_done v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_degenerate;
    x0 = 9; y0 = 9; x1 = 9; y1 = 9;
    in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    checks++;
    if ({out_valid, out_x, out_y, out_last, out_hit}
        !== {1'b1, 8'd9, 7'd9, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL degen_cell got v=%b (%0d,%0d) l=%b h=%b want (9,9) l=1 h=1",
               out_valid, out_x, out_y, out_last, out_hit);
    end
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL degen_ready rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_truncation;
    t_x0 = 0; t_y0 = 0; t_x1 = 10; t_y1 = 0;
    t_in_valid = 1;
    tick;
    t_in_valid = 0;
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({t_out_valid, t_out_x, t_out_y, t_out_last, t_out_hit}
          !== {1'b1, 8'(i), 7'd0, i == 3, 1'b0}) begin
        failures++;
        $display("FAIL trunc_cell%0d got v=%b (%0d,%0d) l=%b h=%b want (%0d,0) l=%0d h=0",
                 i, t_out_valid, t_out_x, t_out_y, t_out_last, t_out_hit, i, i == 3);
      end
      tick;
    end
    checks++;
    if (t_out_valid !== 1'b0 || t_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL trunc_done v=%b rdy=%b want 0 1", t_out_valid, t_in_ready);
    end
  endtask

  task automatic test_backpressure_abort;
    logic rdy[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   ex[4]  = '{0, 1, 1, 1};
    x0 = 0; y0 = 0; x1 = 3; y1 = 1;
    in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    for (int i = 0; i < 4; i++) begin
      out_ready = rdy[i];
      checks++;
      if ({out_valid, out_x, out_y, out_last}
          !== {1'b1, 8'(ex[i]), 7'd0, 1'b0}) begin
        failures++;
        $display("FAIL bp_cycle%0d got v=%b (%0d,%0d) l=%b want (%0d,0) l=0",
                 i, out_valid, out_x, out_y, out_last, ex[i]);
      end
      tick;
    end
    checks++;
    if ({out_valid, out_x, out_y} !== {1'b1, 8'd2, 7'd1}) begin
      failures++;
      $display("FAIL bp_next got v=%b (%0d,%0d) want (2,1)", out_valid, out_x, out_y);
    end
    out_ready = 1;
    abort = 1;
    tick;
    abort = 0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_flush v=%b busy=%b rdy=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
    x0 = 4; y0 = 2; x1 = 4; y1 = 2;
    in_valid = 1;
    tick;
    in_valid = 0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_newray busy=%b want 1", busy);
    end
    tick;
    checks++;
    if ({out_valid, out_x, out_y, out_last, out_hit}
        !== {1'b1, 8'd4, 7'd2, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL abort_newcell got v=%b (%0d,%0d) l=%b h=%b want (4,2) 1 1",
               out_valid, out_x, out_y, out_last, out_hit);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    x0 = 0; y0 = 0; x1 = 3; y1 = 1;
    in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    tick;
    checks++;
    if ({out_valid, out_x} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL midreset_pre got v=%b x=%0d want 1 1", out_valid, out_x);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, out_x, out_y} !== {1'b0, 1'b0, 1'b1, 8'd0, 7'd0}) begin
      failures++;
      $display("FAIL midreset_async got v=%b busy=%b rdy=%b (%0d,%0d) want 0 0 1 (0,0)",
               out_valid, busy, in_ready, out_x, out_y);
    end
    #2 reset = 1'b0;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  initial begin
    test_reset;
    test_shallow;
    test_steep_neg;
    test_degenerate;
    test_truncation;
    test_backpressure_abort;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
